// File: rtl/rx_burst.sv
// rx_burst: energy-detect burst receiver that captures one 16-symbol frame per burst
module rx_burst #(
  parameter int SAMPLE_BITS      = 9,
  parameter int ENERGY_THRESHOLD = 2048,
  parameter int SKIP_SYMBOLS     = 2,
  parameter int TIMEOUT_SAMPLES  = 1024,
  parameter int HOLDOFF_SAMPLES  = 1021
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          arm_i,
  input  logic                          sample_valid_i,
  input  logic signed [SAMPLE_BITS-1:0] inphase_i,
  input  logic signed [SAMPLE_BITS-1:0] quadrature_i,
  input  logic                          symbol_valid_i,
  input  logic                          symbol_i,
  output logic                          is_armed,
  output logic                          burst_detect,
  output logic                          burst_done,
  output logic                          burst_abort,
  output logic [10:0]                   payload_o,
  output logic                          tail_ok_o
);
  localparam int MW = SAMPLE_BITS + 1;
  localparam int AW = SAMPLE_BITS + 5;
  typedef enum logic [2:0] {IDLE, SEARCH, SYNC, CAPTURE, HOLDOFF} state_t;
  state_t state, next;
  logic [MW-1:0] abs_i, abs_q, mag, mag_q;
  logic [AW-1:0] acc, sum;
  logic [3:0] blk_cnt;
  logic [15:0] smp_cnt, word;
  logic [7:0] sym_cnt;
  logic [14:0] shreg;
  logic mag_v, hit, det_n, done_n, abort_n, timeout, holdoff_end, skip_end, last;
  assign abs_i = inphase_i[SAMPLE_BITS-1] ? -MW'(inphase_i) : MW'(inphase_i);
  assign abs_q = quadrature_i[SAMPLE_BITS-1] ? -MW'(quadrature_i) : MW'(quadrature_i);
  assign mag = abs_i + abs_q;
  assign sum = acc + AW'(mag_q);
  assign word = {shreg, symbol_i};
  assign timeout = sample_valid_i && smp_cnt == 16'(TIMEOUT_SAMPLES - 1);
  assign holdoff_end = HOLDOFF_SAMPLES == 0 || (sample_valid_i && smp_cnt == 16'(HOLDOFF_SAMPLES - 1));
  assign skip_end = SKIP_SYMBOLS == 0 || (symbol_valid_i && sym_cnt == 8'(SKIP_SYMBOLS - 1));
  assign last = symbol_valid_i && sym_cnt == 8'd15;
  assign is_armed = state == SEARCH;
  always_comb begin
    next = state;
    det_n = 1'b0;
    done_n = 1'b0;
    abort_n = 1'b0;
    case (state)
      IDLE: next = arm_i ? SEARCH : IDLE;
      SEARCH: begin
        if (!arm_i) next = IDLE;
        else if (hit) begin
          next = SYNC;
          det_n = 1'b1;
        end
      end
      SYNC: begin
        if (timeout) begin
          next = HOLDOFF;
          abort_n = 1'b1;
        end else if (skip_end) next = CAPTURE;
      end
      CAPTURE: begin
        if (last) begin
          next = HOLDOFF;
          done_n = 1'b1;
        end else if (timeout) begin
          next = HOLDOFF;
          abort_n = 1'b1;
        end
      end
      HOLDOFF: next = holdoff_end ? IDLE : HOLDOFF;
      default: next = IDLE;
    endcase
  end
  // energy path: mag register, then block sum/compare, then state change -> detect 2 cycles after the 16th sample
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      burst_detect <= 1'b0;
      burst_done <= 1'b0;
      burst_abort <= 1'b0;
      payload_o <= '0;
      tail_ok_o <= 1'b0;
      mag_q <= '0;
      mag_v <= 1'b0;
      acc <= '0;
      blk_cnt <= '0;
      hit <= 1'b0;
      smp_cnt <= '0;
      sym_cnt <= '0;
      shreg <= '0;
    end else begin
      state <= next;
      burst_detect <= det_n;
      burst_done <= done_n;
      burst_abort <= abort_n;
      if (done_n) begin
        payload_o <= word[13:3];
        tail_ok_o <= &{word[15:14], word[2:0]};
      end
      if (state != SEARCH) begin
        mag_v <= 1'b0;
        acc <= '0;
        blk_cnt <= '0;
        hit <= 1'b0;
      end else begin
        mag_v <= sample_valid_i;
        mag_q <= mag;
        hit <= mag_v && blk_cnt == 4'd15 && sum >= AW'(ENERGY_THRESHOLD);
        if (mag_v) begin
          acc <= blk_cnt == 4'd15 ? '0 : sum;
          blk_cnt <= blk_cnt + 4'd1;
        end
      end
      smp_cnt <= (next != state && next != CAPTURE) ? '0 : smp_cnt + 16'(sample_valid_i);
      sym_cnt <= next != state ? '0 : sym_cnt + 8'(symbol_valid_i);
      if (state == CAPTURE && symbol_valid_i) shreg <= word[14:0];
    end
  end
endmodule

// File: tb/tb_rx_burst.sv
// tb_rx_burst: randomized bench for rx_burst against an event-level reference model
module tb_rx_burst;
  localparam int TH = 2048;
  localparam int SKIP = 2;
  localparam int TO = 1024;
  localparam int HO = 1021;
  logic clock = 1'b0;
  logic resetn, arm, sv, yv, symbol;
  logic signed [8:0] inphase, quadrature;
  logic is_armed, burst_detect, burst_done, burst_abort, tail_ok_o;
  logic [10:0] payload_o;
  int checks = 0, errors = 0, cyc = 0;
  int n_det = 0, n_done = 0, n_abort = 0, exp_det = 0, exp_done = 0, exp_abort = 0;
  int viol = 0, armviol = 0, det_cyc = -1;
  bit quiet = 0, prev_p = 0;
  logic [10:0] exp_pay = '0;
  logic exp_tail = 1'b0;

  rx_burst #(.SAMPLE_BITS(9), .ENERGY_THRESHOLD(TH), .SKIP_SYMBOLS(SKIP),
             .TIMEOUT_SAMPLES(TO), .HOLDOFF_SAMPLES(HO)) dut (
    .clock(clock), .resetn(resetn), .arm_i(arm), .sample_valid_i(sv),
    .inphase_i(inphase), .quadrature_i(quadrature), .symbol_valid_i(yv), .symbol_i(symbol),
    .is_armed(is_armed), .burst_detect(burst_detect), .burst_done(burst_done),
    .burst_abort(burst_abort), .payload_o(payload_o), .tail_ok_o(tail_ok_o)
  );

  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  task automatic tick();
    int np;
    @(posedge clock);
    #1;
    cyc++;
    np = int'(burst_detect) + int'(burst_done) + int'(burst_abort);
    if (np > 1 || (np > 0 && prev_p)) viol++;
    prev_p = np > 0;
    n_det += int'(burst_detect);
    n_done += int'(burst_done);
    n_abort += int'(burst_abort);
    if (burst_detect) det_cyc = cyc;
    if (quiet && is_armed) armviol++;
  endtask

  task automatic gen(input int mode, input int blk, input int k,
                     output logic signed [8:0] i, output logic signed [8:0] q);
    int a, b;
    case (mode)
      0: begin i = blk == 0 ? 9'sd0 : 9'sd100; q = blk == 0 ? 9'sd0 : -9'sd30; end
      1: begin i = 9'h100; q = 9'h100; end
      2: begin i = 9'sd64; q = (blk == 0 && k == 15) ? 9'sd63 : 9'sd64; end
      default: begin
        if (blk >= 12) begin a = -256; b = -256; end
        else if ($urandom_range(0, 2) != 0) begin
          a = int'($urandom_range(0, 120)) - 60;
          b = int'($urandom_range(0, 120)) - 60;
        end else begin
          a = int'($urandom_range(0, 511)) - 256;
          b = int'($urandom_range(0, 511)) - 256;
        end
        i = 9'(a);
        q = 9'(b);
      end
    endcase
  endtask

  // feed blocks until one reaches the threshold; detect expected 2 cycles after its 16th sample
  task automatic search(input int mode);
    int blk, k, sum, e;
    bit hit;
    logic signed [8:0] i, q;
    arm = 1'b1; sv = 1'b0; yv = 1'b0;
    tick();
    chk("armed", 32'(is_armed), 1);
    det_cyc = -1; hit = 0; blk = 0; e = 0;
    while (!hit) begin
      sum = 0; k = 0;
      while (k < 16) begin
        sv = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          inphase = 9'($urandom); quadrature = 9'($urandom); tick();
        end
        if (mode == 3 && k > 0 && $urandom_range(0, 15) == 0) begin
          arm = 1'b0; tick();
          chk("disarm", 32'(is_armed), 0);
          arm = 1'b1; tick();
          sum = 0; k = 0;
        end else begin
          gen(mode, blk, k, i, q);
          inphase = i; quadrature = q; sv = 1'b1;
          tick();
          sum += iabs(int'(i)) + iabs(int'(q));
          k++;
        end
      end
      sv = 1'b0; e = cyc; hit = sum >= TH; blk++;
    end
    exp_det++;
    tick(); tick();
    chk("det_lat", det_cyc - e, 2);
    chk("det_armed", 32'(is_armed), 0);
  endtask

  // kind 0 normal, 1 timeout, 2 completion/timeout tie, 3 stop mid-capture
  task automatic capture(input int kind, input logic [15:0] vec_in, input bit rnd);
    logic [15:0] vec;
    int ns, ny, n;
    bit ev_done, ev_abort, fin;
    vec = rnd ? 16'($urandom) : vec_in;
    ns = 0; ny = 0; n = 0; fin = 0;
    while (!fin && n < 6000) begin
      n++;
      arm = $urandom_range(0, 1) == 1;
      inphase = 9'($urandom); quadrature = 9'($urandom);
      case (kind)
        1: begin sv = $urandom_range(0, 3) != 0; yv = ny < 5 && $urandom_range(0, 1) == 1; end
        2: begin
          sv = (ny < SKIP + 15) ? ($urandom_range(0, 1) == 1 && ns < 400) : 1'b1;
          yv = (ny < SKIP + 15) ? $urandom_range(0, 1) == 1 : ns == TO - 1;
        end
        default: begin sv = $urandom_range(0, 3) == 0; yv = $urandom_range(0, 1) == 1; end
      endcase
      symbol = (yv && ny >= SKIP) ? vec[4'(ny - SKIP)] : 1'($urandom);
      ns += int'(sv);
      ny += int'(yv);
      ev_done = yv && ny == SKIP + 16;
      ev_abort = !ev_done && sv && ns == TO;
      tick();
      if (kind == 3 && ny == SKIP + 5) fin = 1;
      else if (ev_done || ev_abort) begin
        fin = 1;
        if (ev_done) begin
          for (int x = 2; x <= 12; x++) exp_pay = {exp_pay[9:0], vec[4'(x)]};
          exp_tail = vec[0] & vec[1] & vec[13] & vec[14] & vec[15];
        end
        exp_done += int'(ev_done);
        exp_abort += int'(ev_abort);
        chk("done", 32'(burst_done), 32'(ev_done));
        chk("abort", 32'(burst_abort), 32'(ev_abort));
        chk("payload", 32'(payload_o), 32'(exp_pay));
        chk("tail_ok", 32'(tail_ok_o), 32'(exp_tail));
      end
    end
    sv = 1'b0; yv = 1'b0;
    chk("cap_fin", 32'(fin), 1);
  endtask

  task automatic holdoff(input bit arm_end);
    int ns, n;
    ns = 0; n = 0;
    while (ns < HO && n < 8 * HO) begin
      n++;
      sv = $urandom_range(0, 1) == 1;
      yv = $urandom_range(0, 1) == 1;
      symbol = 1'($urandom);
      arm = $urandom_range(0, 3) != 0;
      inphase = 9'h100; quadrature = 9'h100;
      ns += int'(sv);
      tick();
    end
    quiet = 0; sv = 1'b0; yv = 1'b0;
    chk("ho_len", ns, HO);
    chk("ho_idle", 32'(is_armed), 0);
    arm = arm_end;
    tick();
    chk("rearm", 32'(is_armed), 32'(arm_end));
  endtask

  initial begin
    resetn = 1'b0; arm = 1'b1; sv = 1'b1; yv = 1'b1; symbol = 1'b1;
    inphase = 9'sd100; quadrature = 9'sd100;
    repeat (3) tick();
    chk("rst_armed", 32'(is_armed), 0);
    chk("rst_det", 32'(burst_detect), 0);
    chk("rst_done", 32'(burst_done), 0);
    chk("rst_abort", 32'(burst_abort), 0);
    chk("rst_payload", 32'(payload_o), 0);
    chk("rst_tail", 32'(tail_ok_o), 0);
    resetn = 1'b1; arm = 1'b0; sv = 1'b0; yv = 1'b0;
    tick();
    chk("idle", 32'(is_armed), 0);
    search(0); quiet = 1; capture(0, 16'hFAAB, 0);
    chk("pay_spec", 32'(payload_o), 32'(11'b01010101011));
    holdoff(1);
    search(2); quiet = 1; capture(0, 16'hBAAB, 0); holdoff(1);
    search(3); quiet = 1; capture(1, 16'h0000, 0); holdoff(1);
    search(1); quiet = 1; capture(2, 16'($urandom), 0); holdoff(0);
    search(3); quiet = 1; capture(3, 16'hFFFF, 0); quiet = 0;
    resetn = 1'b0;
    tick();
    chk("mid_armed", 32'(is_armed), 0);
    chk("mid_det", 32'(burst_detect), 0);
    chk("mid_done", 32'(burst_done), 0);
    chk("mid_abort", 32'(burst_abort), 0);
    chk("mid_payload", 32'(payload_o), 0);
    chk("mid_tail", 32'(tail_ok_o), 0);
    exp_pay = '0; exp_tail = 1'b0;
    resetn = 1'b1; arm = 1'b1;
    repeat (30) begin
      yv = $urandom_range(0, 1) == 1; symbol = 1'($urandom); tick();
    end
    yv = 1'b0;
    chk("post_rst_search", 32'(is_armed), 1);
    repeat (4) begin
      search(3); quiet = 1; capture(0, 16'h0000, 1); holdoff(1);
    end
    chk("n_detect", n_det, exp_det);
    chk("n_done", n_done, exp_done);
    chk("n_abort", n_abort, exp_abort);
    chk("pulse_excl", viol, 0);
    chk("armed_in_busy", armviol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_burst.md
RX_BURST -- requirements
Module: rx_burst

Interface
REQ-001 The block SHALL have the parameter SAMPLE_BITS, default 9, giving the signed I/Q sample width.
REQ-002 The block SHALL have the parameter ENERGY_THRESHOLD, default 2048, giving the 14-bit block-energy detection threshold.
REQ-003 The block SHALL have the parameter SKIP_SYMBOLS, default 2, giving the number of demodulator symbols discarded after detection (ramp-up).
REQ-004 The block SHALL have the parameter TIMEOUT_SAMPLES, default 1024, giving the maximum valid samples allowed in SYNC+CAPTURE.
REQ-005 The block SHALL have the parameter HOLDOFF_SAMPLES, default 1021, giving the valid samples ignored after a burst ends.
REQ-006 The block SHALL have one clock and a synchronous, active-low reset, with these ports:
- clock  in  1  system clock, all logic on posedge
- resetn  in  1  synchronous active-low reset
- arm_i  in  1  level; high permits burst search
- sample_valid_i  in  1  inphase_i/quadrature_i valid this cycle
- inphase_i  in  SAMPLE_BITS  signed I sample from RF chain
- quadrature_i  in  SAMPLE_BITS  signed Q sample from RF chain
- symbol_valid_i  in  1  demodulator hard decision valid
- symbol_i  in  1  demodulator hard decision
- is_armed  out  1  high in SEARCH only
- burst_detect  out  1  one-cycle pulse on energy detection
- burst_done  out  1  one-cycle pulse; payload_o/tail_ok_o updated
- burst_abort  out  1  one-cycle pulse on timeout
- payload_o  out  11  payload bits of last complete burst
- tail_ok_o  out  1  all five tail bits of last burst were 1

Function
REQ-007 The block SHALL form mag = |I| + |Q| per valid sample as 10-bit unsigned, with |-256| = 256 exact (no saturation).
REQ-008 In SEARCH the block SHALL sum mag over non-overlapping blocks of 16 valid samples into a 14-bit unsigned accumulator (maximum 8192, no overflow), clearing the accumulator and block counter on SEARCH entry.
REQ-009 The block SHALL implement states IDLE, SEARCH, SYNC, CAPTURE and HOLDOFF, one-hot or encoded.
REQ-010 IDLE SHALL go to SEARCH on any cycle with arm_i=1.
REQ-011 SEARCH SHALL go to IDLE on arm_i=0, discarding the partial block.
REQ-012 SEARCH SHALL go to SYNC when a completed block sum >= ENERGY_THRESHOLD, with burst_detect high exactly 2 cycles after the edge sampling the 16th valid sample of that block.
REQ-013 SYNC SHALL discard SKIP_SYMBOLS symbol_valid_i pulses and then enter CAPTURE; with SKIP_SYMBOLS=0 it SHALL enter CAPTURE on the next cycle.
REQ-014 CAPTURE SHALL shift in 16 symbols, symbol index 0 first; indices 0, 1 and 13-15 are tail, and indices 2-12 are payload with index 2 at payload_o[10].
REQ-015 On the cycle after the 16th symbol is accepted, the block SHALL update payload_o and tail_ok_o, pulse burst_done for 1 cycle, and enter HOLDOFF.
REQ-016 The timeout counter SHALL count valid samples from SYNC entry; reaching TIMEOUT_SAMPLES SHALL pulse burst_abort, leave payload_o/tail_ok_o unchanged, and enter HOLDOFF.
REQ-017 If the 16th symbol and the timeout occur in the same cycle, completion SHALL win and burst_abort SHALL stay 0.
REQ-018 HOLDOFF SHALL count HOLDOFF_SAMPLES valid samples and then enter IDLE unconditionally; if arm_i is high, IDLE goes to SEARCH on the following cycle.
REQ-019 arm_i SHALL be ignored in SYNC, CAPTURE and HOLDOFF.
REQ-020 Symbols arriving outside SYNC/CAPTURE SHALL be ignored.
REQ-021 When sample_valid_i and symbol_valid_i are high in the same cycle, both SHALL be processed in that cycle.
REQ-022 burst_detect, burst_done and burst_abort SHALL be mutually exclusive and never high for two consecutive cycles.

Reset
REQ-023 While resetn=0 at a clock edge: state SHALL be IDLE; is_armed, burst_detect, burst_done, burst_abort, tail_ok_o SHALL be 0; payload_o SHALL be 0; all counters and the accumulator SHALL be 0.
REQ-024 Reset asserted mid-CAPTURE SHALL discard the partial burst with no burst_done or burst_abort pulse.

Verification
REQ-025 arm_i=1, 16 samples I=Q=0 -> no detect. Then 16 samples I=100, Q=-30 (sum 2080) -> burst_detect high 2 cycles after the 16th sample; is_armed falls.
REQ-026 After detect, feed symbols 1,1, then 1,1,0,1,0,1,0,1,0,1,0,1,1,1,1,1 -> burst_done; payload_o=11'b01010101011, tail_ok_o=1.
REQ-027 Same as REQ-026 but symbol index 14 = 0 -> burst_done with tail_ok_o=0 and payload unchanged in value.
REQ-028 After detect, feed 5 symbols then only samples -> burst_abort after exactly 1024 valid samples from SYNC entry; payload_o retains its previous value.
REQ-029 Block of 16 samples with I=-256, Q=-256 (sum 8192) -> detect with no wrap. Toggle arm_i=0 during HOLDOFF -> IDLE after 1021 samples, no SEARCH entry.
REQ-030 resetn=0 for 1 cycle mid-CAPTURE -> all outputs 0 next cycle, and no burst_done follows.
